// File: rtl/exe_issue_arbiter_if.sv
// Issue-arbiter handshake bundle between the reservation stations/EXE control and the arbiter.
// The master side drives requests and pipeline status; the slave side returns the grant.
interface exe_issue_arbiter_if #(
  parameter int NREQ  = 3,
  parameter int TAG_W = 6
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*TAG_W-1:0] req_tag;
  logic [NREQ-1:0]       req_long;
  logic [TAG_W-1:0]      rob_head;
  logic                  flush;
  logic                  exe_stall;
  logic [NREQ-1:0]       grant;
  logic                  grant_valid;
  logic [TAG_W-1:0]      grant_tag;
  logic                  unit_busy;
  logic [31:0]           issue_count;

  modport master (
    output req_valid, req_tag, req_long, rob_head, flush, exe_stall,
    input  grant, grant_valid, grant_tag, unit_busy, issue_count
  );

  modport slave (
    input  req_valid, req_tag, req_long, rob_head, flush, exe_stall,
    output grant, grant_valid, grant_tag, unit_busy, issue_count
  );
endinterface

// File: rtl/exe_issue_arbiter.sv
// Oldest-first issue arbiter for the shared execute datapath; blocks issue while
// a long MULT/DIV holds HI/LO and drops everything on a branch flush.
//
//   state | meaning
//   READY | may grant the oldest eligible request
//   BUSY  | long op occupies HI/LO, cnt counts remaining cycles
//   FLUSH | one dead cycle after a flush, scheduling cleared
module exe_issue_arbiter #(
  parameter int NREQ     = 3,
  parameter int TAG_W    = 6,
  parameter int LONG_LAT = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  exe_issue_arbiter_if.slave bus
);
  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNT_W = $clog2(LONG_LAT) + 1;

  typedef enum logic [1:0] {READY, BUSY, FLUSH} state_t;

  state_t            state, state_next;
  logic [CNT_W-1:0]  cnt, cnt_next;
  logic [NREQ-1:0]   mask, grant_next, elig;
  logic [NREQ-1:0]   grant_q;
  logic              grant_valid_q;
  logic [TAG_W-1:0]  grant_tag_q;
  logic [31:0]       issue_count_q;
  logic              win_found;
  logic [IDX_W-1:0]  win_idx;
  logic [TAG_W-1:0]  win_age, age, win_tag;

  assign elig = bus.req_valid & ~mask;

  // Strict less-than keeps the lowest index on equal age.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    win_age   = '0;
    age       = '0;
    for (int i = 0; i < NREQ; i++) begin
      age = bus.req_tag[i*TAG_W +: TAG_W] - bus.rob_head;
      if (elig[i] && (!win_found || age < win_age)) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(i);
        win_age   = age;
      end
    end
  end

  assign win_tag = bus.req_tag[win_idx*TAG_W +: TAG_W];

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    grant_next = '0;
    case (state)
      READY: begin
        if (!bus.flush && !bus.exe_stall && win_found) begin
          grant_next = NREQ'(1) << win_idx;
          if (bus.req_long[win_idx]) begin
            state_next = BUSY;
            cnt_next   = CNT_W'(LONG_LAT - 1);
          end
        end
      end
      BUSY: begin
        if (!bus.exe_stall) begin
          cnt_next = cnt - CNT_W'(1);
          if (cnt <= CNT_W'(1)) state_next = READY;
        end
      end
      FLUSH: begin
        state_next = READY;
        cnt_next   = '0;
      end
      default: begin
        state_next = READY;
        cnt_next   = '0;
      end
    endcase
    // Flush overrides everything, including a stall and any grant found this cycle.
    if (bus.flush) begin
      state_next = FLUSH;
      cnt_next   = '0;
      grant_next = '0;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state         <= READY;
      cnt           <= '0;
      mask          <= '0;
      grant_q       <= '0;
      grant_valid_q <= 1'b0;
      grant_tag_q   <= '0;
      issue_count_q <= '0;
    end else begin
      state         <= state_next;
      cnt           <= cnt_next;
      mask          <= grant_next;
      grant_q       <= grant_next;
      grant_valid_q <= |grant_next;
      grant_tag_q   <= (|grant_next) ? win_tag : '0;
      if (|grant_next) issue_count_q <= issue_count_q + 32'd1;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.grant_valid = grant_valid_q;
  assign bus.grant_tag   = grant_tag_q;
  assign bus.unit_busy   = (state != READY);
  assign bus.issue_count = issue_count_q;
endmodule

// File: tb/tb_exe_issue_arbiter.sv
// Directed bench for exe_issue_arbiter: age ordering, tie-break, long-op occupancy,
// stalls, flushes and asynchronous reset, all against hand-computed expectations.
module tb_exe_issue_arbiter;
  logic        CLK   = 1'b0;
  logic        RESET = 1'b0;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_count = 32'd0;

  always #5 CLK = ~CLK;

  exe_issue_arbiter_if #(.NREQ(3), .TAG_W(6)) bus();

  exe_issue_arbiter #(.NREQ(3), .TAG_W(6), .LONG_LAT(4)) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bus)
  );

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic [2:0] v, input logic [2:0] l,
                       input logic [5:0] t0, input logic [5:0] t1, input logic [5:0] t2);
    bus.req_valid = v;
    bus.req_long  = l;
    bus.req_tag   = {t2, t1, t0};
  endtask

  task automatic test_reset();
    drive(3'b000, 3'b000, 6'h00, 6'h00, 6'h00);
    bus.rob_head = 6'h00; bus.flush = 1'b0; bus.exe_stall = 1'b0;
    #3;
    checks++; if (bus.grant !== 3'b000 || bus.grant_valid !== 1'b0) begin errors++;
      $display("FAIL reset_grant grant=%b valid=%b expected 000/0", bus.grant, bus.grant_valid); end
    checks++; if (bus.grant_tag !== 6'h00 || bus.unit_busy !== 1'b0 || bus.issue_count !== 32'd0) begin errors++;
      $display("FAIL reset_misc tag=%h busy=%b count=%0d expected 0/0/0", bus.grant_tag, bus.unit_busy, bus.issue_count); end
    @(negedge CLK); RESET = 1'b1;
    step();
  endtask

  task automatic test_age();
    bus.rob_head = 6'h3C;
    drive(3'b011, 3'b000, 6'h02, 6'h3E, 6'h00);
    step(); exp_count++;
    checks++; if (bus.grant !== 3'b010 || bus.grant_tag !== 6'h3E || bus.grant_valid !== 1'b1) begin errors++;
      $display("FAIL age_first grant=%b tag=%h expected 010/3e", bus.grant, bus.grant_tag); end
    step(); exp_count++;
    checks++; if (bus.grant !== 3'b001 || bus.grant_tag !== 6'h02) begin errors++;
      $display("FAIL age_second grant=%b tag=%h expected 001/02", bus.grant, bus.grant_tag); end
    bus.req_valid = 3'b000;
    step();
    checks++; if (bus.grant !== 3'b000 || bus.grant_valid !== 1'b0) begin errors++;
      $display("FAIL age_idle grant=%b valid=%b expected 000/0", bus.grant, bus.grant_valid); end
    checks++; if (bus.issue_count !== exp_count) begin errors++;
      $display("FAIL age_count count=%0d expected %0d", bus.issue_count, exp_count); end
  endtask

  task automatic test_tie();
    bus.rob_head = 6'h00;
    drive(3'b111, 3'b000, 6'h05, 6'h05, 6'h05);
    step(); exp_count++;
    checks++; if (bus.grant !== 3'b001) begin errors++;
      $display("FAIL tie_first grant=%b expected 001", bus.grant); end
    step(); exp_count++;
    checks++; if (bus.grant !== 3'b010) begin errors++;
      $display("FAIL tie_masked grant=%b expected 010", bus.grant); end
    bus.req_valid = 3'b000;
    step();
  endtask

  task automatic test_wrap();
    bus.rob_head = 6'h3C;
    drive(3'b111, 3'b000, 6'h3B, 6'h3C, 6'h01);
    step(); exp_count++;
    checks++; if (bus.grant !== 3'b010 || bus.grant_tag !== 6'h3C) begin errors++;
      $display("FAIL wrap_head grant=%b tag=%h expected 010/3c", bus.grant, bus.grant_tag); end
    bus.req_valid = 3'b101;
    step(); exp_count++;
    checks++; if (bus.grant !== 3'b100 || bus.grant_tag !== 6'h01) begin errors++;
      $display("FAIL wrap_low grant=%b tag=%h expected 100/01", bus.grant, bus.grant_tag); end
    bus.req_valid = 3'b001;
    step(); exp_count++;
    checks++; if (bus.grant !== 3'b001 || bus.grant_tag !== 6'h3B) begin errors++;
      $display("FAIL wrap_young grant=%b tag=%h expected 001/3b", bus.grant, bus.grant_tag); end
    bus.req_valid = 3'b000;
    step();
  endtask

  // stall_cycles stall edges start at edge 2; grant for req 0 lands at edge 5 + stall_cycles.
  task automatic test_long(input int stall_cycles, input string name);
    logic [2:0] exp_g;
    logic       exp_b;
    int         last;
    last = 5 + stall_cycles;
    bus.rob_head = 6'h10;
    drive(3'b100, 3'b100, 6'h11, 6'h00, 6'h10);
    step(); exp_count++;
    checks++; if (bus.grant !== 3'b100 || bus.unit_busy !== 1'b1 || bus.grant_tag !== 6'h10) begin errors++;
      $display("FAIL %s_issue grant=%b busy=%b tag=%h expected 100/1/10", name, bus.grant, bus.unit_busy, bus.grant_tag); end
    drive(3'b001, 3'b000, 6'h11, 6'h00, 6'h10);
    for (int e = 2; e <= last; e++) begin
      bus.exe_stall = (e - 2 < stall_cycles);
      step();
      exp_g = (e == last) ? 3'b001 : 3'b000;
      exp_b = (e < last - 1);
      checks++; if (bus.grant !== exp_g || bus.unit_busy !== exp_b) begin errors++;
        $display("FAIL %s_edge%0d grant=%b busy=%b expected %b/%b", name, e, bus.grant, bus.unit_busy, exp_g, exp_b); end
    end
    bus.exe_stall = 1'b0;
    exp_count++;
    bus.req_valid = 3'b000;
    step();
    checks++; if (bus.issue_count !== exp_count) begin errors++;
      $display("FAIL %s_count count=%0d expected %0d", name, bus.issue_count, exp_count); end
  endtask

  task automatic test_flush_busy();
    bus.rob_head = 6'h10;
    drive(3'b100, 3'b100, 6'h11, 6'h00, 6'h10);
    step(); exp_count++;
    drive(3'b001, 3'b000, 6'h11, 6'h00, 6'h10);
    step();
    bus.flush = 1'b1;
    step();
    checks++; if (bus.grant !== 3'b000 || bus.unit_busy !== 1'b1) begin errors++;
      $display("FAIL flush_edge grant=%b busy=%b expected 000/1", bus.grant, bus.unit_busy); end
    bus.flush = 1'b0;
    step();
    checks++; if (bus.grant !== 3'b000 || bus.unit_busy !== 1'b0) begin errors++;
      $display("FAIL flush_dead grant=%b busy=%b expected 000/0", bus.grant, bus.unit_busy); end
    step(); exp_count++;
    checks++; if (bus.grant !== 3'b001) begin errors++;
      $display("FAIL flush_resume grant=%b expected 001", bus.grant); end
    bus.req_valid = 3'b000;
    step();
  endtask

  task automatic test_flush_stall();
    bus.rob_head = 6'h00;
    drive(3'b111, 3'b000, 6'h01, 6'h02, 6'h03);
    bus.flush = 1'b1; bus.exe_stall = 1'b1;
    step();
    checks++; if (bus.grant !== 3'b000 || bus.grant_valid !== 1'b0 || bus.unit_busy !== 1'b1) begin errors++;
      $display("FAIL flush_stall grant=%b valid=%b busy=%b expected 000/0/1", bus.grant, bus.grant_valid, bus.unit_busy); end
    checks++; if (bus.issue_count !== exp_count) begin errors++;
      $display("FAIL flush_stall_count count=%0d expected %0d", bus.issue_count, exp_count); end
    bus.flush = 1'b0; bus.exe_stall = 1'b0;
    step();
    checks++; if (bus.grant !== 3'b000 || bus.unit_busy !== 1'b0) begin errors++;
      $display("FAIL flush_stall_dead grant=%b busy=%b expected 000/0", bus.grant, bus.unit_busy); end
    step(); exp_count++;
    checks++; if (bus.grant !== 3'b001 || bus.grant_tag !== 6'h01) begin errors++;
      $display("FAIL flush_stall_resume grant=%b tag=%h expected 001/01", bus.grant, bus.grant_tag); end
    bus.req_valid = 3'b000;
    step();
  endtask

  task automatic test_stall_ready();
    bus.rob_head = 6'h00;
    drive(3'b010, 3'b000, 6'h00, 6'h07, 6'h00);
    bus.exe_stall = 1'b1;
    step();
    checks++; if (bus.grant !== 3'b000 || bus.unit_busy !== 1'b0) begin errors++;
      $display("FAIL stall_ready grant=%b busy=%b expected 000/0", bus.grant, bus.unit_busy); end
    bus.exe_stall = 1'b0;
    step(); exp_count++;
    checks++; if (bus.grant !== 3'b010 || bus.grant_tag !== 6'h07) begin errors++;
      $display("FAIL stall_release grant=%b tag=%h expected 010/07", bus.grant, bus.grant_tag); end
    bus.req_valid = 3'b000;
    step();
  endtask

  task automatic test_reset_mid_busy();
    bus.rob_head = 6'h00;
    for (int k = 0; k < 5; k++) begin
      drive(3'b001, 3'b000, 6'h04, 6'h00, 6'h00);
      step(); exp_count++;
      bus.req_valid = 3'b000;
      step();
    end
    drive(3'b100, 3'b100, 6'h00, 6'h00, 6'h09);
    step(); exp_count++;
    bus.req_valid = 3'b000;
    checks++; if (bus.unit_busy !== 1'b1 || bus.issue_count !== exp_count) begin errors++;
      $display("FAIL pre_reset busy=%b count=%0d expected 1/%0d", bus.unit_busy, bus.issue_count, exp_count); end
    #2 RESET = 1'b0;
    #1;
    checks++; if (bus.grant !== 3'b000 || bus.grant_valid !== 1'b0 || bus.unit_busy !== 1'b0 || bus.issue_count !== 32'd0) begin errors++;
      $display("FAIL async_reset grant=%b valid=%b busy=%b count=%0d expected 000/0/0/0", bus.grant, bus.grant_valid, bus.unit_busy, bus.issue_count); end
    exp_count = 32'd0;
    @(negedge CLK);
    RESET = 1'b1;
    drive(3'b001, 3'b000, 6'h04, 6'h00, 6'h00);
    step(); exp_count++;
    checks++; if (bus.grant !== 3'b001 || bus.unit_busy !== 1'b0 || bus.issue_count !== exp_count) begin errors++;
      $display("FAIL post_reset grant=%b busy=%b count=%0d expected 001/0/%0d", bus.grant, bus.unit_busy, bus.issue_count, exp_count); end
    bus.req_valid = 3'b000;
    step();
  endtask

  initial begin
    test_reset();
    test_age();
    test_tie();
    test_wrap();
    test_long(0, "long");
    test_long(2, "long_stall");
    test_flush_busy();
    test_flush_stall();
    test_stall_ready();
    test_reset_mid_busy();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
